// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master engine between N_REQ clients.
// Each grant runs one engine transaction, with a watchdog that aborts a hung engine.
module i2c_bus_arbiter #(
  parameter int N_REQ     = 2,
  parameter int TO_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [7*N_REQ-1:0]   req_addr,
  input  logic [N_REQ-1:0]     req_rw,
  input  logic [8*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [7:0]           rdata,
  output logic                 err,
  output logic                 m_start,
  output logic [6:0]           m_addr,
  output logic                 m_rw,
  output logic [7:0]           m_wdata,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic                 m_nack,
  input  logic [7:0]           m_rdata
);

  localparam int WD_W = $clog2(TO_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        rr_ptr;
  logic [1:0]        win_idx;
  logic [WD_W-1:0]   wd;
  logic              wd_expired;
  logic              pick_found;
  logic [1:0]        pick_idx;
  logic [N_REQ-1:0]  pick_onehot;
  logic [6:0]        pick_addr;
  logic              pick_rw;
  logic [7:0]        pick_wdata;
  logic [1:0]        ptr_after;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Scan requesters starting at rr_ptr with wrap; the first set req wins.
  always_comb begin
    state_next  = state;
    pick_found  = 1'b0;
    pick_idx    = 2'd0;
    pick_onehot = '0;
    pick_addr   = 7'd0;
    pick_rw     = 1'b0;
    pick_wdata  = 8'd0;
    wd_expired  = (wd == WD_W'(TO_CYCLES - 1));
    ptr_after   = (int'(win_idx) == N_REQ - 1) ? 2'd0 : win_idx + 2'd1;

    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pick_found && req[i] && ((int'(rr_ptr) + k) % N_REQ == i)) begin
          pick_found     = 1'b1;
          pick_idx       = 2'(i);
          pick_onehot[i] = 1'b1;
          pick_addr      = req_addr[7*i +: 7];
          pick_rw        = req_rw[i];
          pick_wdata     = req_wdata[8*i +: 8];
        end
      end
    end

    case (state)
      S_IDLE:  if (pick_found && !m_busy) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (m_done || wd_expired) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // m_start is registered out of ISSUE; m_done takes priority over the watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant   <= '0;
      done    <= '0;
      rdata   <= 8'd0;
      err     <= 1'b0;
      m_start <= 1'b0;
      m_addr  <= 7'd0;
      m_rw    <= 1'b0;
      m_wdata <= 8'd0;
      rr_ptr  <= 2'd0;
      win_idx <= 2'd0;
      wd      <= '0;
    end else begin
      m_start <= 1'b0;
      done    <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found && !m_busy) begin
            grant   <= pick_onehot;
            win_idx <= pick_idx;
            m_addr  <= pick_addr;
            m_rw    <= pick_rw;
            m_wdata <= pick_wdata;
          end
        end
        S_ISSUE: begin
          m_start <= 1'b1;
          wd      <= '0;
        end
        S_WAIT: begin
          if (m_done) begin
            rdata <= m_rdata;
            err   <= m_nack;
            done  <= grant;
          end else if (wd_expired) begin
            err  <= 1'b1;
            done <= grant;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_DONE: begin
          grant  <= '0;
          rr_ptr <= ptr_after;
        end
        default: ;
      endcase
    end
  end

endmodule
